// File: rtl/fetch_unit.sv
// Instruction fetch front end: drives the combinational ROM, queues {pc, word, fault}
// in order toward decode, flushes on redirect and halts sequential fetch after a fault.
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 64,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           DEPTH      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  input  logic                  rom_illegal_i,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] inst_pc_o,
  output logic                  inst_fault_o
);

  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam int unsigned      CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HALT  = 1'b1
  } state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  w_fetch_en;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_pop;
  logic                  w_push;

  logic [ADDR_WIDTH-1:0] r_mem_pc    [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_data  [DEPTH];
  logic                  r_mem_fault [DEPTH];

  assign w_pop  = inst_valid_o && inst_ready_i;
  // A full queue still accepts a new word when the head leaves in the same cycle.
  assign w_push = w_fetch_en && !redirect_valid_i && ((r_count != FULL_CNT) || w_pop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    if (redirect_valid_i) begin
      w_state_nxt = ST_FETCH;
    end else if (w_push && rom_illegal_i) begin
      w_state_nxt = ST_HALT;
    end
  end

  always_comb begin
    w_fetch_en = (r_state == ST_FETCH);
  end

  // Redirect wins over everything: pointers restart at zero and the PC reloads.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pc     <= RESET_PC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid_i) begin
      r_pc     <= redirect_pc_i;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (!rom_illegal_i) begin
          r_pc <= r_pc + ADDR_WIDTH'(4);
        end
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: queue storage is deliberately not reset; the outputs are masked while
  // the queue is empty, so stale contents are never visible.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]    <= r_pc;
      r_mem_data[r_wr_ptr]  <= rom_data_i;
      r_mem_fault[r_wr_ptr] <= rom_illegal_i;
    end
  end

  assign rom_addr_o   = r_pc;
  assign inst_valid_o = (r_count != '0);
  assign inst_o       = inst_valid_o ? r_mem_data[r_rd_ptr]  : '0;
  assign inst_pc_o    = inst_valid_o ? r_mem_pc[r_rd_ptr]    : '0;
  assign inst_fault_o = inst_valid_o ? r_mem_fault[r_rd_ptr] : 1'b0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenario tasks plus a randomized run, all observed
// against a queue-based reference model of the fetch front end and an aliasing ROM.
module tb_fetch_unit;

  localparam int AW    = 64;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          clk_i  = 1'b0;
  logic          rst_ni = 1'b1;
  logic [AW-1:0] rom_addr_o;
  logic [DW-1:0] rom_data_i;
  logic          rom_illegal_i;
  logic          redirect_valid_i = 1'b0;
  logic [AW-1:0] redirect_pc_i    = '0;
  logic          inst_valid_o;
  logic          inst_ready_i     = 1'b1;
  logic [DW-1:0] inst_o;
  logic [AW-1:0] inst_pc_o;
  logic          inst_fault_o;

  int n_vec = 0;
  int n_err = 0;

  fetch_unit #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .RESET_PC  (64'h0),
    .DEPTH     (DEPTH)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .rom_addr_o      (rom_addr_o),
    .rom_data_i      (rom_data_i),
    .rom_illegal_i   (rom_illegal_i),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i   (redirect_pc_i),
    .inst_valid_o    (inst_valid_o),
    .inst_ready_i    (inst_ready_i),
    .inst_o          (inst_o),
    .inst_pc_o       (inst_pc_o),
    .inst_fault_o    (inst_fault_o)
  );

  always #5 clk_i = ~clk_i;

  // 16-word ROM aliased every 64 bytes; misaligned addresses fault and return 0.
  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    case (a[5:2])
      4'd0:    return 32'h0000_0013;
      4'd1:    return 32'h0010_0093;
      4'd2:    return 32'h0020_0113;
      4'd3:    return 32'h0030_0193;
      default: return 32'hC0DE_0000 | {28'd0, a[5:2]};
    endcase
  endfunction

  assign rom_illegal_i = |rom_addr_o[1:0];
  assign rom_data_i    = rom_illegal_i ? '0 : rom_word(rom_addr_o);

  // Reference model: an in-order queue of fetched entries, a PC and a halted flag.
  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] data;
    logic          fault;
  } ent_t;

  ent_t          mq[$];
  logic [AW-1:0] m_pc   = '0;
  bit            m_halt = 1'b0;

  always @(posedge clk_i or negedge rst_ni) begin
    bit   pop;
    bit   can_push;
    ent_t e;
    if (!rst_ni) begin
      mq.delete();
      m_pc   = '0;
      m_halt = 1'b0;
    end else begin
      pop = (mq.size() != 0) && inst_ready_i;
      if (redirect_valid_i) begin
        mq.delete();
        m_pc   = redirect_pc_i;
        m_halt = 1'b0;
      end else begin
        can_push = !m_halt && ((mq.size() < DEPTH) || pop);
        if (pop) void'(mq.pop_front());
        if (can_push) begin
          e.pc    = m_pc;
          e.fault = (m_pc[1:0] != 2'b00);
          e.data  = e.fault ? '0 : rom_word(m_pc);
          mq.push_back(e);
          if (e.fault) m_halt = 1'b1;
          else         m_pc   = m_pc + 64'd4;
        end
      end
    end
  end

  // Every falling edge: the whole visible DUT state must match the model.
  always @(negedge clk_i) begin
    logic          ev;
    logic [AW-1:0] epc;
    logic [DW-1:0] ew;
    logic          ef;
    ev  = (mq.size() != 0);
    epc = ev ? mq[0].pc    : '0;
    ew  = ev ? mq[0].data  : '0;
    ef  = ev ? mq[0].fault : 1'b0;
    n_vec++;
    if ({rom_addr_o, inst_valid_o, inst_pc_o, inst_o, inst_fault_o} !== {m_pc, ev, epc, ew, ef}) begin
      n_err++;
      $display("FAIL model t=%0t: got addr=%h v=%0b pc=%h w=%h f=%0b, want addr=%h v=%0b pc=%h w=%h f=%0b",
               $time, rom_addr_o, inst_valid_o, inst_pc_o, inst_o, inst_fault_o, m_pc, ev, epc, ew, ef);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end within the time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    logic [DW-1:0] exp_w [4];
    exp_w = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0030_0193};
    inst_ready_i = 1'b1;
    #2 rst_ni = 1'b0;
    #1;
    n_vec++;
    if ({inst_valid_o, rom_addr_o, inst_pc_o, inst_o, inst_fault_o} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got v=%0b addr=%h pc=%h w=%h f=%0b, want all zero",
               inst_valid_o, rom_addr_o, inst_pc_o, inst_o, inst_fault_o);
    end
    tick();
    rst_ni = 1'b1;
    @(negedge clk_i);
    n_vec++;
    if (inst_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_first_cycle: got valid=%0b, want 0", inst_valid_o);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      n_vec++;
      if ({inst_valid_o, inst_pc_o, inst_o, inst_fault_o} !== {1'b1, 64'(4 * i), exp_w[i], 1'b0}) begin
        n_err++;
        $display("FAIL reset_stream[%0d]: got v=%0b pc=%h w=%h f=%0b, want v=1 pc=%h w=%h f=0",
                 i, inst_valid_o, inst_pc_o, inst_o, inst_fault_o, 64'(4 * i), exp_w[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    tick();
    inst_ready_i = 1'b0;
    rst_ni       = 1'b0;
    #1 rst_ni    = 1'b1;
    repeat (5) @(negedge clk_i);
    n_vec++;
    if ({rom_addr_o, inst_valid_o, inst_pc_o} !== {64'd8, 1'b1, 64'd0}) begin
      n_err++;
      $display("FAIL backpressure_hold: got addr=%h v=%0b pc=%h, want addr=8 v=1 pc=0",
               rom_addr_o, inst_valid_o, inst_pc_o);
    end
    tick();
    inst_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      n_vec++;
      if ({inst_valid_o, inst_pc_o} !== {1'b1, 64'(4 * i)}) begin
        n_err++;
        $display("FAIL backpressure_drain[%0d]: got v=%0b pc=%h, want v=1 pc=%h",
                 i, inst_valid_o, inst_pc_o, 64'(4 * i));
      end
    end
  endtask

  task automatic test_redirect_full();
    tick();
    inst_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    tick();
    inst_ready_i     = 1'b1;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 64'h40;
    tick();
    redirect_valid_i = 1'b0;
    @(negedge clk_i);
    n_vec++;
    if ({inst_valid_o, rom_addr_o} !== {1'b0, 64'h40}) begin
      n_err++;
      $display("FAIL redirect_flush: got v=%0b addr=%h, want v=0 addr=40", inst_valid_o, rom_addr_o);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      n_vec++;
      if ({inst_valid_o, inst_pc_o} !== {1'b1, 64'h40 + 64'(4 * i)}) begin
        n_err++;
        $display("FAIL redirect_stream[%0d]: got v=%0b pc=%h, want v=1 pc=%h",
                 i, inst_valid_o, inst_pc_o, 64'h40 + 64'(4 * i));
      end
    end
  endtask

  task automatic test_fault();
    tick();
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 64'h42;
    tick();
    redirect_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    n_vec++;
    if ({inst_valid_o, inst_pc_o, inst_fault_o, inst_o} !== {1'b1, 64'h42, 1'b1, 32'h0}) begin
      n_err++;
      $display("FAIL fault_entry: got v=%0b pc=%h f=%0b w=%h, want v=1 pc=42 f=1 w=0",
               inst_valid_o, inst_pc_o, inst_fault_o, inst_o);
    end
    repeat (3) begin
      @(negedge clk_i);
      n_vec++;
      if ({inst_valid_o, rom_addr_o} !== {1'b0, 64'h42}) begin
        n_err++;
        $display("FAIL fault_halt: got v=%0b addr=%h, want v=0 addr=42", inst_valid_o, rom_addr_o);
      end
    end
    tick();
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 64'h80;
    tick();
    redirect_valid_i = 1'b0;
    @(negedge clk_i);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      n_vec++;
      if ({inst_valid_o, inst_pc_o, inst_fault_o} !== {1'b1, 64'h80 + 64'(4 * i), 1'b0}) begin
        n_err++;
        $display("FAIL fault_resume[%0d]: got v=%0b pc=%h f=%0b, want v=1 pc=%h f=0",
                 i, inst_valid_o, inst_pc_o, inst_fault_o, 64'h80 + 64'(4 * i));
      end
    end
  endtask

  task automatic test_reset_mid();
    repeat (3) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    n_vec++;
    if ({inst_valid_o, rom_addr_o} !== {1'b0, 64'h0}) begin
      n_err++;
      $display("FAIL reset_async: got v=%0b addr=%h, want v=0 addr=0", inst_valid_o, rom_addr_o);
    end
    tick();
    rst_ni = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    n_vec++;
    if ({inst_valid_o, inst_pc_o} !== {1'b1, 64'h0}) begin
      n_err++;
      $display("FAIL reset_restart: got v=%0b pc=%h, want v=1 pc=0", inst_valid_o, inst_pc_o);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_pc [3];
    exp_pc = '{64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
    tick();
    inst_ready_i     = 1'b1;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = exp_pc[0];
    tick();
    redirect_valid_i = 1'b0;
    @(negedge clk_i);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      n_vec++;
      if ({inst_valid_o, inst_pc_o, inst_o} !== {1'b1, exp_pc[i], rom_word(exp_pc[i])}) begin
        n_err++;
        $display("FAIL wrap[%0d]: got v=%0b pc=%h w=%h, want v=1 pc=%h w=%h",
                 i, inst_valid_o, inst_pc_o, inst_o, exp_pc[i], rom_word(exp_pc[i]));
      end
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] pc;
    for (int i = 0; i < 600; i++) begin
      tick();
      inst_ready_i     = ($urandom_range(0, 99) < 65);
      redirect_valid_i = ($urandom_range(0, 99) < 7);
      pc               = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
      redirect_pc_i    = pc;
    end
    tick();
    redirect_valid_i = 1'b0;
    inst_ready_i     = 1'b1;
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_redirect_full();
    test_fault();
    test_reset_mid();
    test_wrap();
    test_random();
    repeat (4) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the RV64I core. It is the initiator toward the combinational instruction ROM: it drives the fetch address, captures the returned instruction word and alignment-fault flag, and buffers them in a small in-order queue. The queue presents {pc, instruction, fault} to decode over a valid/ready handshake. Redirects from execute flush the queue, and an instruction fault halts sequential fetch until the next redirect.

## Interface
- `ADDR_WIDTH`, 64, fetch address / PC width
- `DATA_WIDTH`, 32, instruction word width
- `RESET_PC`, 64'h0, PC loaded on reset
- `DEPTH`, 2, fetch queue entries (power of two, ≥2)

- `clk_i`  in  1  clock; all state updates on the rising edge
- `rst_ni`  in  1  asynchronous, active-low reset
- `rom_addr_o`  out  ADDR_WIDTH  fetch address to the ROM (= `pc_q`)
- `rom_data_i`  in  DATA_WIDTH  ROM word for `rom_addr_o`, same cycle
- `rom_illegal_i`  in  1  ROM alignment fault for `rom_addr_o`, same cycle
- `redirect_valid_i`  in  1  flush the queue and restart fetch
- `redirect_pc_i`  in  ADDR_WIDTH  new PC, sampled when `redirect_valid_i`=1
- `inst_valid_o`  out  1  queue head is valid
- `inst_ready_i`  in  1  decode accepts the head
- `inst_o`  out  DATA_WIDTH  head instruction word
- `inst_pc_o`  out  ADDR_WIDTH  head PC
- `inst_fault_o`  out  1  head entry faulted (misaligned fetch)

## Operation
- State: `pc_q`, `state_q` ∈ {FETCH, HALT}, and a circular queue (`rd_ptr`, `wr_ptr`, `count` of width clog2(DEPTH)+1).
- `rom_addr_o` = `pc_q` at all times. The ROM is combinational, so the response is valid in the same cycle.
- `pop` = `inst_valid_o` && `inst_ready_i`.
- `push` = (`state_q`==FETCH) && !`redirect_valid_i` && (`count`<DEPTH || `pop`).
- On push:
  - Write {`pc_q`, `rom_data_i`, `rom_illegal_i`} at `wr_ptr`.
  - If `rom_illegal_i`=0: `pc_q` ← `pc_q`+4. The add wraps modulo 2^ADDR_WIDTH.
  - If `rom_illegal_i`=1: `pc_q` holds and `state_q` ← HALT. The entry word is whatever the ROM returns (0).
- HALT: no pushes. `rom_addr_o` stays at the faulting PC. The queue drains normally.
- Redirect has priority over push, pop and HALT:
  - `count`←0 and `rd_ptr`=`wr_ptr`←0.
  - `pc_q` ← `redirect_pc_i`.
  - `state_q` ← FETCH.
  - A pop in the same cycle counts as consumed by decode, but the queue is cleared regardless.
- A misaligned `redirect_pc_i` is not checked locally. The next fetch returns `rom_illegal_i`=1 and takes the fault path.
- Outputs when `count`=0: `inst_valid_o`=0 and `inst_o`/`inst_pc_o`/`inst_fault_o`=0. Otherwise they show the head entry.
- `count` update: +1 on push only, −1 on pop only, unchanged on both. Queue order is strictly in order.

## Timing
- Reset (async assert, sync-safe release):
  - `pc_q`=RESET_PC, `state_q`=FETCH, queue empty.
  - `rom_addr_o`=RESET_PC, `inst_valid_o`=0, `inst_o`=0, `inst_pc_o`=0, `inst_fault_o`=0.
- Fetch-to-output latency is 1 cycle. A word fetched in cycle N is at the head in cycle N+1 if the queue was empty.
- First `inst_valid_o`=1 is in the 2nd cycle after reset release.
- Redirect latency: `redirect_valid_i` in cycle N gives `rom_addr_o`=new PC in N+1 and the first new `inst_valid_o` in N+2. `inst_valid_o`=0 in N+1.
- Sustained throughput with `inst_ready_i`=1 constant is 1 instruction per cycle.
- Full queue with pop in the same cycle: push proceeds, with no bubble.
- Full queue without pop: no push and `pc_q` holds; `rom_addr_o` is stable.
- `inst_valid_o`/`inst_o`/`inst_pc_o`/`inst_fault_o` hold stable while `inst_valid_o`=1 && `inst_ready_i`=0 (no redirect).
- Reset asserted mid-operation: all state and outputs return to reset values immediately, without waiting for a clock edge.

## Test plan
- Reset release with RESET_PC=0, ROM words 0..3 = 0x00000013, 0x00100093, 0x00200113, 0x00300193, `inst_ready_i`=1:
  - `inst_pc_o` = 0, 4, 8, 12 on consecutive cycles starting the 2nd cycle after release, with matching words and `inst_fault_o`=0.
- Backpressure: hold `inst_ready_i`=0 for 5 cycles.
  - `count` saturates at DEPTH and `rom_addr_o` freezes at 8.
  - The head stays pc=0.
  - Releasing ready delivers 0, 4, 8, … with no gaps or duplicates.
- Redirect to 0x40 while the queue is full and `inst_ready_i`=1:
  - Queue is flushed, `inst_valid_o`=0 next cycle, then `inst_pc_o`=0x40, 0x44.
  - No stale PC ever appears.
- Redirect to 0x42:
  - One entry with `inst_pc_o`=0x42, `inst_fault_o`=1, `inst_o`=0.
  - `rom_addr_o` stays 0x42 and no further entries appear.
  - A following redirect to 0x80 resumes with 0x80, 0x84.
- Assert `rst_ni`=0 mid-stream between clock edges:
  - `inst_valid_o`=0 and `rom_addr_o`=RESET_PC immediately.
  - Fetch restarts from RESET_PC after release.
- Wrap-around: redirect to 2^64−8 with ROM aliasing. Expected `inst_pc_o` sequence: 0xFFFF_FFFF_FFFF_FFF8, …FFFC, 0x0.
